// File: rtl/updown_seq_monitor_if.sv
// Bundle between the up/down counter tap and its sequence monitor.
// master drives the sampled counter/direction and clear; slave returns status.
interface updown_seq_monitor_if #(
   parameter int LAP_W = 8
);
   logic                    dir;
   logic [1:0]              cnt_in;
   logic                    clr;
   logic                    wrap_up;
   logic                    wrap_dn;
   logic signed [LAP_W-1:0] lap_count;
   logic                    err_step;
   logic                    err_sticky;
   logic                    stalled;

   modport master (
      output dir, cnt_in, clr,
      input  wrap_up, wrap_dn, lap_count, err_step, err_sticky, stalled
   );

   modport slave (
      input  dir, cnt_in, clr,
      output wrap_up, wrap_dn, lap_count, err_step, err_sticky, stalled
   );
endinterface

// File: rtl/updown_seq_monitor.sv
// Checks every sampled step of a 2-bit up/down counter; counts signed laps, flags illegal steps and stalls.
// All status is registered (valid one cycle after the sampling edge); no backpressure, samples every clock.
module updown_seq_monitor #(
   parameter int LAP_W       = 8,
   parameter int STALL_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   updown_seq_monitor_if.slave  mon
);

   typedef enum logic [1:0] {
      ARM     = 2'd0,
      RUN     = 2'd1,
      STALLED = 2'd2
   } state_t;

   localparam logic signed [LAP_W-1:0] LAP_MAX   = {1'b0, {(LAP_W-1){1'b1}}};
   localparam logic signed [LAP_W-1:0] LAP_MIN   = {1'b1, {(LAP_W-1){1'b0}}};
   localparam logic signed [LAP_W-1:0] LAP_ONE   = {{(LAP_W-1){1'b0}}, 1'b1};
   localparam logic [7:0]              STALL_LIM = 8'(STALL_LIMIT);

   state_t                  state_q, state_d;
   logic [1:0]              prev_cnt_q;
   logic                    prev_dir_q;
   logic [7:0]              hold_q, hold_d;
   logic signed [LAP_W-1:0] lap_q, lap_d;
   logic                    wrap_up_q, wrap_up_d;
   logic                    wrap_dn_q, wrap_dn_d;
   logic                    err_step_q, err_step_d;
   logic                    err_sticky_q, err_sticky_d;
   logic [1:0]              exp_cnt;

   // 2-bit arithmetic gives the modulo-4 wrap for free
   assign exp_cnt = prev_dir_q ? (prev_cnt_q - 2'd1) : (prev_cnt_q + 2'd1);

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      lap_d        = lap_q;
      wrap_up_d    = 1'b0;
      wrap_dn_d    = 1'b0;
      err_step_d   = 1'b0;
      err_sticky_d = err_sticky_q;

      if (mon.clr) begin
         state_d      = ARM;
         hold_d       = 8'd0;
         lap_d        = '0;
         err_sticky_d = 1'b0;
      end else begin
         case (state_q)
            ARM: begin
               state_d = RUN;
               hold_d  = 8'd0;
            end
            RUN, STALLED: begin
               if (mon.cnt_in == exp_cnt) begin
                  hold_d = 8'd0;
                  if (prev_cnt_q == 2'd3 && !prev_dir_q) begin
                     wrap_up_d = 1'b1;
                     if (lap_q != LAP_MAX) lap_d = lap_q + LAP_ONE;
                  end
                  if (prev_cnt_q == 2'd0 && prev_dir_q) begin
                     wrap_dn_d = 1'b1;
                     if (lap_q != LAP_MIN) lap_d = lap_q - LAP_ONE;
                  end
               end else if (mon.cnt_in == prev_cnt_q) begin
                  hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
               end else begin
                  err_step_d   = 1'b1;
                  err_sticky_d = 1'b1;
                  hold_d       = 8'd0;
               end
               // Any change of value clears the hold run, which also drops STALLED
               state_d = (hold_d > STALL_LIM) ? STALLED : RUN;
            end
            default: state_d = ARM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ARM;
         prev_cnt_q   <= 2'd0;
         prev_dir_q   <= 1'b0;
         hold_q       <= 8'd0;
         lap_q        <= '0;
         wrap_up_q    <= 1'b0;
         wrap_dn_q    <= 1'b0;
         err_step_q   <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_cnt_q   <= mon.cnt_in;
         prev_dir_q   <= mon.dir;
         hold_q       <= hold_d;
         lap_q        <= lap_d;
         wrap_up_q    <= wrap_up_d;
         wrap_dn_q    <= wrap_dn_d;
         err_step_q   <= err_step_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign mon.wrap_up    = wrap_up_q;
   assign mon.wrap_dn    = wrap_dn_q;
   assign mon.lap_count  = lap_q;
   assign mon.err_step   = err_step_q;
   assign mon.err_sticky = err_sticky_q;
   assign mon.stalled    = (state_q == STALLED);

endmodule
